shared_mem_responder: RTL and testbench

- Memory-side responder for the data-memory request interface driven by the TessiaX32 cores' memory stage.
- Arbitrates single-word read/write requests from NUM_CORES cores with a round-robin policy.
- Serves one request at a time from a word-addressed on-chip RAM with a fixed access latency.
- Returns a one-cycle response pulse to the requesting core.

---
 rtl/shared_mem_responder.sv | 210 +++++++++++++++++++++
 tb/tb_shared_mem_responder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_mem_responder.sv
// -----------------------------------------------------------------------------
// shared_mem_responder
//
// Memory-side responder for the cores' data-memory request interface.
// Several cores raise single-word read/write requests; a round-robin arbiter
// accepts one at a time, the word-addressed on-chip RAM is accessed a fixed
// LATENCY cycles after acceptance, and a one-cycle response pulse is returned
// to the requesting core.
//
// Ports:
//   clk         system clock, all state on the rising edge
//   reset       asynchronous, active-high reset
//   req_valid   per-core request valid
//   req_write   per-core 1=write, 0=read
//   req_addr    per-core byte address, core i in bits [32*i+31:32*i]
//   req_wdata   per-core write data, packed like req_addr
//   req_ready   one-hot grant; a request is accepted at an edge where valid&ready
//   resp_valid  one-hot, one-cycle response pulse
//   resp_rdata  read data, meaningful only while resp_valid is nonzero
//   busy        high while a transaction is in flight
// -----------------------------------------------------------------------------
module shared_mem_responder #(
    parameter int NUM_CORES  = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CORES-1:0]            req_valid,
    input  logic [NUM_CORES-1:0]            req_write,
    input  logic [NUM_CORES*32-1:0]         req_addr,
    input  logic [NUM_CORES*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_CORES-1:0]            req_ready,
    output logic [NUM_CORES-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]           resp_rdata,
    output logic                            busy
);

    localparam int IDX_W = $clog2(NUM_CORES);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
    localparam logic [NUM_CORES-1:0] ONE_HOT0 = {{(NUM_CORES-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } stateType;

    stateType                  state_r;
    stateType                  stateNext_s;
    logic [IDX_W-1:0]          rrPtr_r;
    logic [3:0]                count_r;
    logic [IDX_W-1:0]          core_r;
    logic                      write_r;
    logic [ADDR_WIDTH-1:0]     word_r;
    logic [DATA_WIDTH-1:0]     wdata_r;
    logic [NUM_CORES-1:0]      respValid_r;
    logic [DATA_WIDTH-1:0]     respRdata_r;
    logic                      busy_r;

    logic [IDX_W-1:0]          grantIdx_s;
    logic                      anyGrant_s;
    logic                      accept_s;
    logic                      commit_s;
    logic [ADDR_WIDTH-1:0]     selWord_s;
    logic [DATA_WIDTH-1:0]     selWdata_s;
    logic                      selWrite_s;
    logic [IDX_W-1:0]          opCore_s;
    logic                      opWrite_s;
    logic [ADDR_WIDTH-1:0]     opWord_s;
    logic [DATA_WIDTH-1:0]     opWdata_s;
    logic                      unusedAddrBits_s;

    logic [DATA_WIDTH-1:0]     mem [DEPTH];

    // Core index base+k, wrapped modulo NUM_CORES (NUM_CORES need not be a power of two).
    function automatic logic [IDX_W-1:0] wrapIdx(input logic [IDX_W-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        if (sum >= NUM_CORES) begin
            sum = sum - NUM_CORES;
        end else begin
            sum = sum;
        end
        return IDX_W'(sum);
    endfunction

    // Address bits outside the word index are deliberately ignored (aliasing, no alignment check).
    assign unusedAddrBits_s = ^req_addr;

    // Round-robin search: first valid core at or above rrPtr_r, wrapping around.
    always_comb begin
        grantIdx_s = '0;
        anyGrant_s = 1'b0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (!anyGrant_s && req_valid[wrapIdx(rrPtr_r, k)]) begin
                grantIdx_s = wrapIdx(rrPtr_r, k);
                anyGrant_s = 1'b1;
            end else begin
                anyGrant_s = anyGrant_s;
            end
        end
    end

    // Acceptance only in IDLE; reset suppresses it so nothing commits while reset is held.
    assign accept_s  = (state_r == IDLE) && anyGrant_s && !reset;
    assign req_ready = accept_s ? (ONE_HOT0 << grantIdx_s) : '0;

    assign selWord_s  = req_addr[32*grantIdx_s + 2 +: ADDR_WIDTH];
    assign selWdata_s = req_wdata[DATA_WIDTH*grantIdx_s +: DATA_WIDTH];
    assign selWrite_s = req_write[grantIdx_s];

    // With LATENCY=1 the commit edge is the accept edge, so operands come straight from the request.
    always_comb begin
        if (state_r == IDLE) begin
            opCore_s  = grantIdx_s;
            opWrite_s = selWrite_s;
            opWord_s  = selWord_s;
            opWdata_s = selWdata_s;
        end else begin
            opCore_s  = core_r;
            opWrite_s = write_r;
            opWord_s  = word_r;
            opWdata_s = wdata_r;
        end
    end

    // Next-state logic; commit_s marks the edge that enters RESP (RAM access edge).
    always_comb begin
        stateNext_s = state_r;
        commit_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (LATENCY == 1) begin
                        stateNext_s = RESP;
                        commit_s    = 1'b1;
                    end else begin
                        stateNext_s = BUSY;
                    end
                end else begin
                    stateNext_s = IDLE;
                end
            end
            BUSY: begin
                if (count_r == 4'd1) begin
                    stateNext_s = RESP;
                    commit_s    = 1'b1;
                end else begin
                    stateNext_s = BUSY;
                end
            end
            RESP: begin
                stateNext_s = IDLE;
            end
            default: begin
                stateNext_s = IDLE;
            end
        endcase
    end

    // Control state, transaction latch and registered response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            rrPtr_r     <= '0;
            count_r     <= 4'd0;
            core_r      <= '0;
            write_r     <= 1'b0;
            word_r      <= '0;
            wdata_r     <= '0;
            respValid_r <= '0;
            respRdata_r <= '0;
            busy_r      <= 1'b0;
        end else begin
            state_r <= stateNext_s;
            busy_r  <= (stateNext_s != IDLE);
            if (accept_s) begin
                core_r  <= grantIdx_s;
                write_r <= selWrite_s;
                word_r  <= selWord_s;
                wdata_r <= selWdata_s;
                rrPtr_r <= wrapIdx(grantIdx_s, 1);
                count_r <= LAT_M1;
            end else if (state_r == BUSY) begin
                count_r <= count_r - 4'd1;
            end
            if (commit_s) begin
                respValid_r <= ONE_HOT0 << opCore_s;
                respRdata_r <= opWrite_s ? '0 : mem[opWord_s];
            end else begin
                respValid_r <= '0;
            end
        end
    end

    // RAM write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (commit_s && opWrite_s) begin
            mem[opWord_s] <= opWdata_s;
        end
    end

    assign resp_valid = respValid_r;
    assign resp_rdata = respRdata_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_shared_mem_responder.sv
// -----------------------------------------------------------------------------
// Testbench for shared_mem_responder. Two instances share the same request
// inputs: dut0 with LATENCY=2 and dut1 with LATENCY=1. Directed tables check
// exact cycle behaviour; a randomized phase checks dut0 against a
// transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_shared_mem_responder;

    localparam int NC = 4;
    localparam int L0 = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   reqValid;
    logic [3:0]   reqWrite;
    logic [127:0] reqAddr;
    logic [127:0] reqWdata;
    logic [3:0]   ready0, resp0, ready1, resp1;
    logic [31:0]  rdata0, rdata1;
    logic         busy0, busy1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    shared_mem_responder #(.NUM_CORES(4), .ADDR_WIDTH(10), .DATA_WIDTH(32), .LATENCY(2)) dut0 (
        .clk(clk), .reset(reset), .req_valid(reqValid), .req_write(reqWrite),
        .req_addr(reqAddr), .req_wdata(reqWdata), .req_ready(ready0),
        .resp_valid(resp0), .resp_rdata(rdata0), .busy(busy0)
    );

    shared_mem_responder #(.NUM_CORES(4), .ADDR_WIDTH(10), .DATA_WIDTH(32), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(reqValid), .req_write(reqWrite),
        .req_addr(reqAddr), .req_wdata(reqWdata), .req_ready(ready1),
        .resp_valid(resp1), .resp_rdata(rdata1), .busy(busy1)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [3:0]  w;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  rdy;
        logic [3:0]  rsp;
        logic        bsy;
        logic        chk;
        logic [31:0] rd;
    } row_t;

    row_t tbl0[$];
    row_t tbl1[$];

    function automatic row_t mk(input logic rst, input logic [3:0] v, input logic [3:0] w,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [3:0] rdy, input logic [3:0] rsp, input logic bsy,
                                input logic chk, input logic [31:0] rd);
        row_t r;
        r.rst = rst; r.v = v; r.w = w; r.addr = addr; r.wd = wd;
        r.rdy = rdy; r.rsp = rsp; r.bsy = bsy; r.chk = chk; r.rd = rd;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one table row (all cores see the same addr/wdata), sample mid-cycle, advance.
    task automatic applyRow(input row_t r, input int which, input int n);
        logic [3:0]  aRdy, aRsp;
        logic [31:0] aRd;
        logic        aBsy;
        reset    = r.rst;
        reqValid = r.v;
        reqWrite = r.w;
        reqAddr  = {4{r.addr}};
        reqWdata = {4{r.wd}};
        #2;
        if (which == 0) begin
            aRdy = ready0; aRsp = resp0; aRd = rdata0; aBsy = busy0;
        end else begin
            aRdy = ready1; aRsp = resp1; aRd = rdata1; aBsy = busy1;
        end
        check($sformatf("dut%0d row%0d req_ready", which, n), 32'(aRdy), 32'(r.rdy));
        check($sformatf("dut%0d row%0d resp_valid", which, n), 32'(aRsp), 32'(r.rsp));
        check($sformatf("dut%0d row%0d busy", which, n), 32'(aBsy), 32'(r.bsy));
        if (r.chk) begin
            check($sformatf("dut%0d row%0d resp_rdata", which, n), aRd, r.rd);
        end
        @(posedge clk);
        #1;
    endtask

    // Reference model state (transaction level, indexed by cycle number).
    logic [31:0] mMem [1024];
    bit          mKnown [1024];
    bit          mIn;
    int          mAcc, mCore, mWord, mRr;
    bit          mWrite, mChk;
    logic [31:0] mWd, mRd;

    initial begin
        localparam logic [31:0] A = 32'h0000_0100;
        localparam logic [31:0] D = 32'hDEAD_BEEF;
        logic [3:0]  rv, rw, lastAcc, eRdy, eRsp, acc;
        logic [31:0] ra [4];
        logic [31:0] rdw [4];
        bit          found;
        int          gIdx;

        reset = 1'b1; reqValid = 4'd0; reqWrite = 4'd0; reqAddr = '0; reqWdata = '0;
        @(posedge clk);
        #1;

        // Write then read back, LATENCY=2.
        tbl0.push_back(mk(1'b1, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 32'h0));
        tbl0.push_back(mk(1'b0, 4'h1, 4'h1, A, D, 4'h1, 4'h0, 1'b0, 1'b0, 32'h0));
        tbl0.push_back(mk(1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 4'h0, 1'b1, 1'b0, 32'h0));
        tbl0.push_back(mk(1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 4'h1, 1'b1, 1'b1, 32'h0));
        tbl0.push_back(mk(1'b0, 4'h1, 4'h0, A, 32'h0, 4'h1, 4'h0, 1'b0, 1'b0, 32'h0));
        tbl0.push_back(mk(1'b0, 4'h0, 4'h0, A, 32'h0, 4'h0, 4'h0, 1'b1, 1'b0, 32'h0));
        tbl0.push_back(mk(1'b0, 4'h0, 4'h0, A, 32'h0, 4'h0, 4'h1, 1'b1, 1'b1, D));
        // All four cores read from reset: grants 0,1,2,3 every three cycles.
        tbl0.push_back(mk(1'b1, 4'h0, 4'h0, A, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 32'h0));
        tbl0.push_back(mk(1'b0, 4'hF, 4'h0, A, 32'h0, 4'h1, 4'h0, 1'b0, 1'b0, 32'h0));
        tbl0.push_back(mk(1'b0, 4'hE, 4'h0, A, 32'h0, 4'h0, 4'h0, 1'b1, 1'b0, 32'h0));
        tbl0.push_back(mk(1'b0, 4'hE, 4'h0, A, 32'h0, 4'h0, 4'h1, 1'b1, 1'b1, D));
        tbl0.push_back(mk(1'b0, 4'hE, 4'h0, A, 32'h0, 4'h2, 4'h0, 1'b0, 1'b0, 32'h0));
        tbl0.push_back(mk(1'b0, 4'hC, 4'h0, A, 32'h0, 4'h0, 4'h0, 1'b1, 1'b0, 32'h0));
        tbl0.push_back(mk(1'b0, 4'hC, 4'h0, A, 32'h0, 4'h0, 4'h2, 1'b1, 1'b1, D));
        tbl0.push_back(mk(1'b0, 4'hC, 4'h0, A, 32'h0, 4'h4, 4'h0, 1'b0, 1'b0, 32'h0));
        tbl0.push_back(mk(1'b0, 4'h8, 4'h0, A, 32'h0, 4'h0, 4'h0, 1'b1, 1'b0, 32'h0));
        tbl0.push_back(mk(1'b0, 4'h8, 4'h0, A, 32'h0, 4'h0, 4'h4, 1'b1, 1'b1, D));
        tbl0.push_back(mk(1'b0, 4'h8, 4'h0, A, 32'h0, 4'h8, 4'h0, 1'b0, 1'b0, 32'h0));
        tbl0.push_back(mk(1'b0, 4'h0, 4'h0, A, 32'h0, 4'h0, 4'h0, 1'b1, 1'b0, 32'h0));
        tbl0.push_back(mk(1'b0, 4'h0, 4'h0, A, 32'h0, 4'h0, 4'h8, 1'b1, 1'b1, D));
        // Round-robin: core2 first, then cores 1 and 3 together -> 3 before 1.
        tbl0.push_back(mk(1'b0, 4'h4, 4'h0, A, 32'h0, 4'h4, 4'h0, 1'b0, 1'b0, 32'h0));
        tbl0.push_back(mk(1'b0, 4'hA, 4'h0, A, 32'h0, 4'h0, 4'h0, 1'b1, 1'b0, 32'h0));
        tbl0.push_back(mk(1'b0, 4'hA, 4'h0, A, 32'h0, 4'h0, 4'h4, 1'b1, 1'b1, D));
        tbl0.push_back(mk(1'b0, 4'hA, 4'h0, A, 32'h0, 4'h8, 4'h0, 1'b0, 1'b0, 32'h0));
        tbl0.push_back(mk(1'b0, 4'h2, 4'h0, A, 32'h0, 4'h0, 4'h0, 1'b1, 1'b0, 32'h0));
        tbl0.push_back(mk(1'b0, 4'h2, 4'h0, A, 32'h0, 4'h0, 4'h8, 1'b1, 1'b1, D));
        tbl0.push_back(mk(1'b0, 4'h2, 4'h0, A, 32'h0, 4'h2, 4'h0, 1'b0, 1'b0, 32'h0));
        tbl0.push_back(mk(1'b0, 4'h0, 4'h0, A, 32'h0, 4'h0, 4'h0, 1'b1, 1'b0, 32'h0));
        tbl0.push_back(mk(1'b0, 4'h0, 4'h0, A, 32'h0, 4'h0, 4'h2, 1'b1, 1'b1, D));
        // Aliasing: 0x1004 and 0x0007 are both word 1.
        tbl0.push_back(mk(1'b0, 4'h1, 4'h1, 32'h1004, 32'h55, 4'h1, 4'h0, 1'b0, 1'b0, 32'h0));
        tbl0.push_back(mk(1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 4'h0, 1'b1, 1'b0, 32'h0));
        tbl0.push_back(mk(1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 4'h1, 1'b1, 1'b1, 32'h0));
        tbl0.push_back(mk(1'b0, 4'h1, 4'h0, 32'h7, 32'h0, 4'h1, 4'h0, 1'b0, 1'b0, 32'h0));
        tbl0.push_back(mk(1'b0, 4'h0, 4'h0, 32'h7, 32'h0, 4'h0, 4'h0, 1'b1, 1'b0, 32'h0));
        tbl0.push_back(mk(1'b0, 4'h0, 4'h0, 32'h7, 32'h0, 4'h0, 4'h1, 1'b1, 1'b1, 32'h55));
        // Reset mid-BUSY of a write to word 5: old data survives, rr_ptr back to 0.
        tbl0.push_back(mk(1'b0, 4'h1, 4'h1, 32'h14, 32'hA5A5, 4'h1, 4'h0, 1'b0, 1'b0, 32'h0));
        tbl0.push_back(mk(1'b0, 4'h0, 4'h0, 32'h14, 32'h0, 4'h0, 4'h0, 1'b1, 1'b0, 32'h0));
        tbl0.push_back(mk(1'b0, 4'h0, 4'h0, 32'h14, 32'h0, 4'h0, 4'h1, 1'b1, 1'b1, 32'h0));
        tbl0.push_back(mk(1'b0, 4'h1, 4'h1, 32'h14, 32'h1234, 4'h1, 4'h0, 1'b0, 1'b0, 32'h0));
        tbl0.push_back(mk(1'b1, 4'h0, 4'h0, 32'h14, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 32'h0));
        tbl0.push_back(mk(1'b0, 4'h3, 4'h0, 32'h14, 32'h0, 4'h1, 4'h0, 1'b0, 1'b0, 32'h0));
        tbl0.push_back(mk(1'b0, 4'h2, 4'h0, 32'h14, 32'h0, 4'h0, 4'h0, 1'b1, 1'b0, 32'h0));
        tbl0.push_back(mk(1'b0, 4'h2, 4'h0, 32'h14, 32'h0, 4'h0, 4'h1, 1'b1, 1'b1, 32'hA5A5));
        tbl0.push_back(mk(1'b0, 4'h2, 4'h0, 32'h14, 32'h0, 4'h2, 4'h0, 1'b0, 1'b0, 32'h0));
        tbl0.push_back(mk(1'b0, 4'h0, 4'h0, 32'h14, 32'h0, 4'h0, 4'h0, 1'b1, 1'b0, 32'h0));
        tbl0.push_back(mk(1'b0, 4'h0, 4'h0, 32'h14, 32'h0, 4'h0, 4'h2, 1'b1, 1'b1, 32'hA5A5));
        tbl0.push_back(mk(1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 32'h0));

        // LATENCY=1: core1 write then back-to-back reads.
        tbl1.push_back(mk(1'b1, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 32'h0));
        tbl1.push_back(mk(1'b0, 4'h2, 4'h2, 32'h8, 32'h77, 4'h2, 4'h0, 1'b0, 1'b0, 32'h0));
        tbl1.push_back(mk(1'b0, 4'h0, 4'h0, 32'h8, 32'h0, 4'h0, 4'h2, 1'b1, 1'b1, 32'h0));
        tbl1.push_back(mk(1'b0, 4'h2, 4'h0, 32'h8, 32'h0, 4'h2, 4'h0, 1'b0, 1'b0, 32'h0));
        tbl1.push_back(mk(1'b0, 4'h2, 4'h0, 32'h8, 32'h0, 4'h0, 4'h2, 1'b1, 1'b1, 32'h77));
        tbl1.push_back(mk(1'b0, 4'h2, 4'h0, 32'h8, 32'h0, 4'h2, 4'h0, 1'b0, 1'b0, 32'h0));
        tbl1.push_back(mk(1'b0, 4'h0, 4'h0, 32'h8, 32'h0, 4'h0, 4'h2, 1'b1, 1'b1, 32'h77));
        tbl1.push_back(mk(1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 32'h0));

        for (int i = 0; i < tbl0.size(); i++) applyRow(tbl0[i], 0, i);
        for (int i = 0; i < tbl1.size(); i++) applyRow(tbl1[i], 1, i);

        // Randomized phase against the reference model (dut0 only).
        reset = 1'b1; reqValid = 4'h0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mIn = 1'b0; mRr = 0; mChk = 1'b0; mRd = 32'h0; mAcc = 0; mCore = 0;
        for (int i = 0; i < 1024; i++) begin
            mKnown[i] = 1'b0;
            mMem[i]   = 32'h0;
        end
        rv = 4'h0; rw = 4'h0; lastAcc = 4'h0;
        for (int i = 0; i < NC; i++) begin
            ra[i] = 32'h0; rdw[i] = 32'h0;
        end

        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int i = 0; i < NC; i++) begin
                if (lastAcc[i]) rv[i] = 1'b0;
                if (rv[i]) begin
                    if ($urandom_range(0, 9) == 0) rv[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    rv[i]  = 1'b1;
                    rw[i]  = 1'($urandom_range(0, 1));
                    ra[i]  = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
                    rdw[i] = $urandom;
                end
            end
            reqValid = rv;
            reqWrite = rw;
            for (int i = 0; i < NC; i++) begin
                reqAddr[32*i +: 32]  = ra[i];
                reqWdata[32*i +: 32] = rdw[i];
            end
            #2;

            eRdy = 4'h0; found = 1'b0; gIdx = 0;
            if (!mIn) begin
                for (int k = 0; k < NC; k++) begin
                    if (!found && rv[(mRr + k) % NC]) begin
                        found = 1'b1;
                        gIdx  = (mRr + k) % NC;
                        eRdy  = 4'(1 << gIdx);
                    end
                end
            end
            eRsp = (mIn && cyc == mAcc + L0) ? 4'(1 << mCore) : 4'h0;
            check($sformatf("rand cyc%0d req_ready", cyc), 32'(ready0), 32'(eRdy));
            check($sformatf("rand cyc%0d resp_valid", cyc), 32'(resp0), 32'(eRsp));
            check($sformatf("rand cyc%0d busy", cyc), 32'(busy0), 32'(mIn));
            if (eRsp != 4'h0 && mChk) begin
                check($sformatf("rand cyc%0d resp_rdata", cyc), rdata0, mRd);
            end

            acc     = eRdy & rv;
            lastAcc = acc;
            if (mIn && cyc == mAcc + L0) mIn = 1'b0;
            if (acc != 4'h0) begin
                mIn    = 1'b1;
                mAcc   = cyc;
                mCore  = gIdx;
                mWrite = rw[gIdx];
                mWord  = int'((ra[gIdx] >> 2) % 32'd1024);
                mWd    = rdw[gIdx];
                mRr    = (gIdx + 1) % NC;
            end
            if (mIn && cyc == mAcc + L0 - 1) begin
                if (mWrite) begin
                    mMem[mWord]   = mWd;
                    mKnown[mWord] = 1'b1;
                    mRd  = 32'h0;
                    mChk = 1'b1;
                end else begin
                    mRd  = mMem[mWord];
                    mChk = mKnown[mWord];
                end
            end
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
